// File: rtl/can_pkg.sv
// Shared constants, state type and bit-timing helpers for the CAN receive front end.
package can_pkg;

    localparam logic CAN_DOMINANT  = 1'b0;
    localparam logic CAN_RECESSIVE = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } can_state_t;

    function automatic int calc_bit_cyc(input int clk_mhz, input int rate_kbps);
        return (clk_mhz * 1000) / rate_kbps;
    endfunction

    function automatic int calc_sample_pt(input int bit_cyc);
        return (bit_cyc * 3) / 4;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; reset value is a parameter.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic q_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= RST_VAL;
            q_reg    <= RST_VAL;
        end else begin
            meta_reg <= d;
            q_reg    <= meta_reg;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/can_rx_sample.sv
// CAN RX bit timing: synchronise the line, hard-resync on falling edges and emit one
// majority-voted bit per bit period around the 75% sample point.
module can_rx_sample
    import can_pkg::*;
#(
    parameter int clk_speed_MHz      = 100,
    parameter int can_bit_rate_Kbits = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic din,
    output logic dout,
    output logic dvalid
);

    localparam int BIT_CYC   = calc_bit_cyc(clk_speed_MHz, can_bit_rate_Kbits);
    localparam int SAMPLE_PT = calc_sample_pt(BIT_CYC);
    localparam int CNT_W     = $clog2(BIT_CYC);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] WIN_LO   = CNT_W'(SAMPLE_PT - 1);
    localparam logic [CNT_W-1:0] WIN_HI   = CNT_W'(SAMPLE_PT + 1);

    can_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [1:0]       smp_reg, smp_next;
    logic             din_s;
    logic             din_prev_reg;
    logic             fall;
    logic             in_window;
    logic             run_active;
    logic             vote;
    logic             dout_reg, dout_next;
    logic             dvalid_reg, dvalid_next;

    sync_2ff #(
        .RST_VAL(CAN_RECESSIVE)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (din),
        .q    (din_s)
    );

    assign fall       = (din_prev_reg == CAN_RECESSIVE) && (din_s == CAN_DOMINANT);
    assign in_window  = (cnt_reg >= WIN_LO) && (cnt_reg <= WIN_HI);
    assign run_active = (state_reg == RUN) && en;

    // The first two samples are registered; the third is taken straight from din_s
    // on the same edge that publishes the vote.
    for (genvar gi = 0; gi < 2; gi++) begin : g_smp
        localparam logic [CNT_W-1:0] SMP_AT = CNT_W'(SAMPLE_PT - 1 + gi);
        assign smp_next[gi] = (run_active && (cnt_reg == SMP_AT)) ? din_s : smp_reg[gi];
    end

    assign vote = (smp_reg[0] & smp_reg[1]) | (smp_reg[0] & din_s) | (smp_reg[1] & din_s);

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        dout_next   = dout_reg;
        dvalid_next = 1'b0;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (en) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!en) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = (cnt_reg == CNT_LAST) ? '0 : cnt_reg + 1'b1;
                    // Edges inside the sample window are treated as noise, not bit starts.
                    if (fall && !in_window) begin
                        cnt_next = '0;
                    end
                    if (cnt_reg == WIN_HI) begin
                        dout_next   = vote;
                        dvalid_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            smp_reg      <= {2{CAN_RECESSIVE}};
            din_prev_reg <= CAN_RECESSIVE;
            dout_reg     <= CAN_RECESSIVE;
            dvalid_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            smp_reg      <= smp_next;
            din_prev_reg <= din_s;
            dout_reg     <= dout_next;
            dvalid_reg   <= dvalid_next;
        end
    end

    assign dout   = dout_reg;
    assign dvalid = dvalid_reg;

endmodule

// File: tb/tb_can_rx_sample.sv
// Randomised bench for can_rx_sample: a cycle-level bit-timing reference model plus
// directed checks for framing, glitches, drift, disable and reset.
module tb_can_rx_sample;

    localparam int BC = (100 * 1000) / 1000;
    localparam int SP = (BC * 3) / 4;

    logic clk;
    logic rst_n;
    logic en;
    logic din;
    logic dout;
    logic dvalid;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state: edge index, origin edge of the current bit, delayed line history.
    longint m_n      = 0;
    longint m_origin = 0;
    int     m_phase  = 0;
    int     m_cnt    = 0;
    bit     m_run    = 0;
    bit     m_dvalid = 0;
    bit     m_dout   = 1;
    bit     h[5];

    longint p_cyc[$];
    bit     p_val[$];
    longint bit_start[$];

    can_rx_sample #(
        .clk_speed_MHz     (100),
        .can_bit_rate_Kbits(1000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .din   (din),
        .dout  (dout),
        .dvalid(dvalid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Model: bit phase is (edges since origin) mod BC; din_s is din from two edges back.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_run    = 0;
                m_dout   = 1;
                m_dvalid = 0;
                m_cnt    = 0;
                for (int k = 0; k < 5; k++) h[k] = 1'b1;
            end else begin
                m_n++;
                for (int k = 4; k > 0; k--) h[k] = h[k-1];
                h[0]     = din;
                m_dvalid = 0;
                if (!m_run) begin
                    if (en) begin
                        m_run    = 1;
                        m_origin = m_n;
                    end
                end else if (!en) begin
                    m_run = 0;
                end else begin
                    m_phase = int'((m_n - 1 - m_origin) % BC);
                    if (m_phase == SP + 1) begin
                        m_dvalid = 1;
                        m_dout   = ((int'(h[2]) + int'(h[3]) + int'(h[4])) >= 2);
                    end
                    if (h[3] && !h[2] && (m_phase < SP - 1 || m_phase > SP + 1))
                        m_origin = m_n;
                end
                m_cnt = m_run ? int'((m_n - m_origin) % BC) : 0;
            end
            #1;
            check_val("dvalid", 32'(dvalid), 32'(m_dvalid));
            check_val("dout", 32'(dout), 32'(m_dout));
            if (dvalid === 1'b1) begin
                p_cyc.push_back(m_n);
                p_val.push_back(dout);
                $display("[TB] bit %0d at cycle %0d dout=%0d", p_cyc.size(), m_n, dout);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic start_test();
        @(negedge clk);
        en = 1'b1;
        p_cyc.delete();
        p_val.delete();
    endtask

    task automatic end_test();
        @(negedge clk);
        en  = 1'b0;
        din = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic drive_bits(input bit bits[$], input int period, input int glitch_at);
        int idx = 0;
        bit_start.delete();
        foreach (bits[b]) begin
            for (int c = 0; c < period; c++) begin
                @(negedge clk);
                if (c == 0) bit_start.push_back(m_n);
                din = (idx == glitch_at) ? 1'b0 : bits[b];
                idx++;
            end
        end
    endtask

    task automatic wait_cnt(input int target, input string tag);
        bit hit = 0;
        for (int i = 0; i < 2 * BC && !hit; i++) begin
            @(negedge clk);
            if (m_cnt == target) hit = 1;
        end
        check_val(tag, 32'(hit), 32'd1);
    endtask

    initial begin
        bit          bits[$];
        logic [15:0] pre;
        longint      t0;
        int          n;
        int          per;
        bit          seen;

        // Reset state
        rst_n = 1'b0;
        en    = 1'b0;
        din   = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        p_cyc.delete();
        repeat (100) @(negedge clk);
        check_val("reset_pulses", 32'(p_cyc.size()), 32'd0);
        check_val("reset_dout", 32'(dout), 32'd1);
        check_val("reset_dvalid", 32'(dvalid), 32'd0);

        // Frame of 83 bits at 100 cycles per bit
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        start_test();
        pre = 16'b0000_1100_0001_0001;
        bits.delete();
        for (int i = 0; i < 83; i++) bits.push_back(i < 16 ? pre[15-i] : 1'($urandom_range(0, 1)));
        drive_bits(bits, BC, -1);
        end_test();
        check_val("frame_count", 32'(p_cyc.size()), 32'd83);
        n = (p_cyc.size() < 83) ? p_cyc.size() : 83;
        for (int i = 0; i < n; i++) begin
            check_val("frame_bit", 32'(p_val[i]), 32'(bits[i]));
            check_val("frame_lat", 32'((p_cyc[i] - bit_start[i] >= 75) && (p_cyc[i] - bit_start[i] <= 80)), 32'd1);
            if (i > 0) check_val("frame_space", 32'(p_cyc[i] - p_cyc[i-1]), 32'd100);
        end

        // Single-clock glitch landing on the middle sample of a recessive bit
        start_test();
        bits.delete();
        bits.push_back(1'b0);
        bits.push_back(1'b1);
        drive_bits(bits, BC, BC + SP + 1);
        end_test();
        check_val("glitch_count", 32'(p_cyc.size()), 32'd2);
        if (p_cyc.size() == 2) begin
            check_val("glitch_bit0", 32'(p_val[0]), 32'd0);
            check_val("glitch_bit1", 32'(p_val[1]), 32'd1);
            check_val("glitch_space", 32'(p_cyc[1] - p_cyc[0]), 32'd100);
        end

        // Slow transmitter: 103-cycle bits, alternating, resynced on each falling edge
        start_test();
        bits.delete();
        for (int i = 0; i < 20; i++) bits.push_back(1'(i % 2));
        drive_bits(bits, 103, -1);
        end_test();
        check_val("drift_count", 32'(p_cyc.size()), 32'd20);
        n = (p_cyc.size() < 20) ? p_cyc.size() : 20;
        for (int i = 0; i < n; i++) begin
            check_val("drift_bit", 32'(p_val[i]), 32'(bits[i]));
            check_val("drift_lat", 32'(p_cyc[i] - bit_start[i]), (i % 2 == 0) ? 32'd80 : 32'd77);
        end

        // Disable mid-bit at cnt 74, then re-enable with a recessive line
        start_test();
        @(negedge clk);
        din = 1'b0;
        wait_cnt(74, "dis_reach_cnt");
        en = 1'b0;
        din = 1'b1;
        repeat (BC) @(negedge clk);
        check_val("dis_pulses", 32'(p_cyc.size()), 32'd0);
        check_val("dis_dout", 32'(dout), 32'd1);
        en = 1'b1;
        t0 = m_n;
        seen = 0;
        for (int i = 0; i < 2 * BC && !seen; i++) begin
            @(negedge clk);
            if (p_cyc.size() > 0) seen = 1;
        end
        check_val("reen_seen", 32'(seen), 32'd1);
        if (seen) begin
            check_val("reen_lat", 32'(p_cyc[0] - (t0 + 1)), 32'd77);
            check_val("reen_dout", 32'(p_val[0]), 32'd1);
        end
        end_test();

        // Reset at cnt 50 of a dominant bit after dominant bits were received
        start_test();
        bits.delete();
        bits.push_back(1'b0);
        bits.push_back(1'b0);
        drive_bits(bits, BC, -1);
        wait_cnt(50, "rst_reach_cnt");
        en    = 1'b0;
        rst_n = 1'b0;
        #1;
        check_val("rst_dout", 32'(dout), 32'd1);
        check_val("rst_dvalid", 32'(dvalid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        p_cyc.delete();
        repeat (150) @(negedge clk);
        check_val("rst_no_pulse", 32'(p_cyc.size()), 32'd0);
        din = 1'b1;

        // Random soak: random data, bit period and one glitch per round
        for (int r = 0; r < 3; r++) begin
            per = $urandom_range(97, 103);
            start_test();
            bits.delete();
            for (int i = 0; i < 80; i++) bits.push_back(1'($urandom_range(0, 1)));
            drive_bits(bits, per, $urandom_range(0, 80 * per - 1));
            end_test();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
